output_handler: RTL and testbench

Transmit-side framer that turns a completed command result into an ASCII packet for the UART transmitter. It is the mirror of the receive-side parser: it emits `L`, one command character, two size characters and N data characters. Each non-`L` character carries one nibble as `0x30 + nibble`. Characters are handed to the byte-wide UART TX over a valid/ready handshake.

---
 rtl/output_handler.sv | 133 +++++++++++++
 tb/tb_output_handler.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/output_handler.sv
// Transmit-side ASCII framer: emits 'L', command, two size characters and N data
// characters (0x30 + nibble) to a byte-wide UART TX over a valid/ready handshake.
`timescale 1ns/1ps
module output_handler #(
  parameter int         BUFFER_WIDTH = 256,
  parameter logic [7:0] CHAR_L       = 8'h4C,
  parameter logic [7:0] CHAR_0       = 8'h30
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [3:0]              command,
  input  logic [7:0]              data_count,
  input  logic [BUFFER_WIDTH-1:0] buffer,
  output logic [7:0]              tx_byte,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [2:0]              state_dbg
);

  localparam int NIBBLES = BUFFER_WIDTH / 4;
  localparam int CW      = $clog2(NIBBLES + 1);
  localparam int IW      = $clog2(NIBBLES);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    SEND_ID      = 3'd1,
    SEND_CMD     = 3'd2,
    SEND_SIZE_HI = 3'd3,
    SEND_SIZE_LO = 3'd4,
    SEND_DATA    = 3'd5,
    DONE         = 3'd6
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           r_left_q, r_left_d;
  logic [3:0]              cmd_q;
  logic [7:0]              cnt_q;
  logic [BUFFER_WIDTH-1:0] buf_q;
  logic                    load;
  logic                    error_d;
  logic                    send_d;
  logic                    hs;
  logic [IW-1:0]           data_idx;
  logic [3:0]              nib;
  logic [7:0]              byte_d;

  // Handshake: a byte transfers on any edge where tx_valid and tx_ready are both high.
  // tx_valid/tx_byte are registered and held unchanged until that transfer happens.
  assign hs        = tx_valid & tx_ready;
  assign state_dbg = state_q;

  always_comb begin
    state_d  = state_q;
    r_left_d = r_left_q;
    load     = 1'b0;
    error_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (int'(data_count) <= NIBBLES) begin
            load     = 1'b1;
            r_left_d = CW'(data_count);
            state_d  = SEND_ID;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      SEND_ID:      if (hs) state_d = SEND_CMD;
      SEND_CMD:     if (hs) state_d = SEND_SIZE_HI;
      SEND_SIZE_HI: if (hs) state_d = SEND_SIZE_LO;
      SEND_SIZE_LO: if (hs) state_d = (r_left_q != '0) ? SEND_DATA : DONE;
      SEND_DATA: begin
        if (hs) begin
          r_left_d = r_left_q - CW'(1);
          if (r_left_q == CW'(1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The outgoing byte is chosen from the state being entered, so it is ready the
  // cycle after the handshake; data goes out most-significant used nibble first.
  always_comb begin
    data_idx = IW'(r_left_d - CW'(1));
    nib      = buf_q[data_idx*4 +: 4];
    send_d   = (state_d != IDLE) && (state_d != DONE);
    byte_d   = 8'h00;
    case (state_d)
      SEND_ID:      byte_d = CHAR_L;
      SEND_CMD:     byte_d = CHAR_0 + {4'h0, cmd_q};
      SEND_SIZE_HI: byte_d = CHAR_0 + {4'h0, cnt_q[7:4]};
      SEND_SIZE_LO: byte_d = CHAR_0 + {4'h0, cnt_q[3:0]};
      SEND_DATA:    byte_d = CHAR_0 + {4'h0, nib};
      default:      byte_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      r_left_q <= '0;
      cmd_q    <= '0;
      cnt_q    <= '0;
      buf_q    <= '0;
      tx_byte  <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_left_q <= r_left_d;
      if (load) begin
        cmd_q <= command;
        cnt_q <= data_count;
        buf_q <= buffer;
      end
      tx_byte  <= byte_d;
      tx_valid <= send_d;
      busy     <= send_d;
      done     <= (state_d == DONE);
      error    <= error_d;
    end
  end

endmodule

// File: tb/tb_output_handler.sv
// Directed bench for output_handler: table of frames with hand-computed header and
// data bytes, plus hand-written sequences for reject, stall and mid-frame reset.
`timescale 1ns/1ps
module tb_output_handler;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   command;
  logic [7:0]   data_count;
  logic [255:0] buffer;
  logic [7:0]   tx_byte;
  logic         tx_valid;
  logic         tx_ready;
  logic         busy;
  logic         done;
  logic         error;
  logic [2:0]   state_dbg;

  output_handler dut (
    .clk(clk), .rst(rst), .start(start), .command(command),
    .data_count(data_count), .buffer(buffer), .tx_byte(tx_byte),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done),
    .error(error), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   cmd;
    logic [7:0]   cnt;
    logic [255:0] data_buf;
    bit           rnd;
    bit           err;
    logic [31:0]  hdr;
    logic [7:0]   first_d;
    logic [7:0]   last_d;
  } vec_t;

  vec_t       vecs[7];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         n_cmp  = 0;
  int         n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference encoding: header then data nibbles from count-1 down to 0.
  task automatic build_expected(input vec_t v);
    exp_q.delete();
    exp_q.push_back(8'h4C);
    exp_q.push_back(8'h30 + {4'h0, v.cmd});
    exp_q.push_back(8'h30 + {4'h0, v.cnt[7:4]});
    exp_q.push_back(8'h30 + {4'h0, v.cnt[3:0]});
    for (int i = int'(v.cnt) - 1; i >= 0; i--)
      exp_q.push_back(8'h30 + {4'h0, v.data_buf[i*4 +: 4]});
  endtask

  task automatic run_vector(input vec_t v, input int id);
    int         c, busy_cnt, done_at, bad;
    bit         err_seen, saw_data, prev_stall;
    logic [7:0] prev_byte;
    @(negedge clk);
    command    = v.cmd;
    data_count = v.cnt;
    buffer     = v.data_buf;
    start      = 1'b1;
    tx_ready   = 1'b1;
    if (v.err) begin
      @(negedge clk);
      start = 1'b0;
      check($sformatf("v%0d err pulse", id), {29'd0, error, tx_valid, busy}, 32'b100);
      @(negedge clk);
      check($sformatf("v%0d err clear", id), {29'd0, error, tx_valid, busy}, 32'b000);
      return;
    end
    build_expected(v);
    got_q.delete();
    c = 0; busy_cnt = 0; done_at = 0; err_seen = 0; saw_data = 0; prev_stall = 0;
    prev_byte = 8'h00;
    while (done_at == 0 && c < 400) begin
      @(negedge clk);
      start = 1'b0;
      c++;
      if (prev_stall)
        check($sformatf("v%0d stall hold", id), {23'd0, tx_valid, tx_byte}, {23'd1, prev_byte});
      if (c == 1)
        check($sformatf("v%0d first cycle", id), {22'd0, busy, tx_valid, tx_byte}, {22'd0, 2'b11, 8'h4C});
      if (busy) busy_cnt++;
      if (error) err_seen = 1;
      if (state_dbg == 3'd5) saw_data = 1;
      if (done) begin
        done_at = c;
        check($sformatf("v%0d done valid", id), {31'd0, tx_valid}, 32'd0);
      end
      // Input churn after start must not disturb the latched frame.
      command    = ~v.cmd;
      data_count = 8'd3;
      buffer     = '1;
      if (v.rnd && c == 5) start = 1'b1;
      tx_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tx_valid && tx_ready) got_q.push_back(tx_byte);
      prev_stall = tx_valid && !tx_ready;
      prev_byte  = tx_byte;
    end
    check($sformatf("v%0d done seen", id), {31'd0, done_at != 0}, 32'd1);
    check($sformatf("v%0d byte count", id), got_q.size(), exp_q.size());
    if (got_q.size() >= 4)
      check($sformatf("v%0d header", id), {got_q[0], got_q[1], got_q[2], got_q[3]}, v.hdr);
    if (v.cnt != 0 && got_q.size() > 4) begin
      check($sformatf("v%0d first data", id), {24'd0, got_q[4]}, {24'd0, v.first_d});
      check($sformatf("v%0d last data", id), {24'd0, got_q[got_q.size()-1]}, {24'd0, v.last_d});
    end
    bad = 0;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i] !== exp_q[i]) bad++;
    check($sformatf("v%0d sequence", id), bad, 0);
    check($sformatf("v%0d data state", id), {31'd0, saw_data}, {31'd0, v.cnt != 0});
    check($sformatf("v%0d no error", id), {31'd0, err_seen}, 32'd0);
    if (!v.rnd) begin
      check($sformatf("v%0d done latency", id), done_at, 5 + int'(v.cnt));
      check($sformatf("v%0d busy cycles", id), busy_cnt, 4 + int'(v.cnt));
    end
    @(negedge clk);
    check($sformatf("v%0d after done", id), {29'd0, done, busy, tx_valid}, 32'd0);
  endtask

  task automatic reset_mid_frame();
    int hs, c;
    bit done_seen;
    @(negedge clk);
    command    = 4'h6;
    data_count = 8'd5;
    buffer     = 256'h12345;
    start      = 1'b1;
    tx_ready   = 1'b1;
    hs = 0; c = 0;
    while (hs < 3 && c < 50) begin
      @(negedge clk);
      start = 1'b0;
      c++;
      if (tx_valid && tx_ready) hs++;
    end
    check("rst handshakes", hs, 3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst outputs", {20'd0, tx_valid, busy, done, error, tx_byte}, 32'd0);
    check("rst state", {29'd0, state_dbg}, 32'd0);
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done || tx_valid) done_seen = 1;
    end
    check("rst no done", {31'd0, done_seen}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{4'h3, 8'd2,  256'hA5, 1'b0, 1'b0, 32'h4C333032, 8'h3A, 8'h35};
    vecs[1] = '{4'hF, 8'd0,  256'h0,  1'b0, 1'b0, 32'h4C3F3030, 8'h00, 8'h00};
    vecs[2] = '{4'h1, 8'd64,
                256'hFEDCBA9876543210_FEDCBA9876543210_FEDCBA9876543210_FEDCBA9876543210,
                1'b0, 1'b0, 32'h4C313430, 8'h3F, 8'h30};
    vecs[3] = '{4'h7, 8'd65, 256'h0,  1'b0, 1'b1, 32'h0, 8'h00, 8'h00};
    vecs[4] = '{4'h2, 8'd1,  256'h9,  1'b0, 1'b0, 32'h4C323031, 8'h39, 8'h39};
    vecs[5] = '{4'hA, 8'd10, 256'h9876543210, 1'b1, 1'b0, 32'h4C3A303A, 8'h39, 8'h30};
    vecs[6] = '{4'h5, 8'd16, 256'hFEDCBA9876543210, 1'b0, 1'b0, 32'h4C353130, 8'h3F, 8'h30};

    rst = 1'b1; start = 1'b0; command = '0; data_count = '0; buffer = '0; tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset outputs", {20'd0, tx_valid, busy, done, error, tx_byte}, 32'd0);
    check("reset state", {29'd0, state_dbg}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    tx_ready = 1'b1;
    @(negedge clk);
    check("idle ready ignored", {30'd0, tx_valid, busy}, 32'd0);

    for (int i = 0; i < 7; i++) run_vector(vecs[i], i);
    reset_mid_frame();
    run_vector(vecs[0], 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
